zcip_weight_feeder: RTL and testbench
=====================================

Name: zcip_weight_feeder

Overview:
Upstream stage of the PE. Accepts one group of 4 lanes x 8 weights (8-bit each), transposes each lane into bit-columns, skips all-zero columns (zero-column skipping, ZCIP) and issues one non-zero column per lane per beat, with its bit index, onto the PE's weight_column/shift_offset bus. It raises zcip_done on the last beat of each group so the PE accumulator closes the group.

Parameters:
LANES, 4, number of BCE lanes fed in parallel (fixed at 4 for the PE; bus widths scale with it)
WBITS, 8, weight width and weights per lane (column width); shift field is 3 bits

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
weights_in  input  256  lane l weight j = weights_in[l*64 + j*8 +: 8]
sign_mode  input  1  sampled with group: 1 = sign-magnitude (bit 7 is sign, never issued as column), 0 = unsigned
in_valid  input  1  group valid
in_ready  output  1  feeder can accept a group
out_ready  input  1  downstream (PE) accepts current beat
weight_column  output  32  lane l column = [l*8 +: 8], bit j = weight j bit shift_offset
shift_offset  output  12  lane l bit index = [l*3 +: 3]
weight_sign_en  output  1  registered sign_mode of the group being issued
weight_valid  output  1  beat valid
zcip_done  output  1  high on last beat of group only

Behaviour:
- One clock; reset is synchronous and active-high. With rst high at a clock edge: state IDLE, masks/columns cleared, weight_column=0, shift_offset=0, weight_sign_en=0, weight_valid=0, zcip_done=0. in_ready=0 while rst asserted.
- States: IDLE, ISSUE, HOLD.
- IDLE: in_ready=1. On in_valid & in_ready: register all weights and sign_mode; per lane compute mask m_l[i] = OR over j of weight j bit i, i=0..7; when sign_mode=1 force m_l[7]=0. Go ISSUE.
- ISSUE (one beat per cycle): per lane, i = index of lowest set bit of m_l; weight_column lane = transposed column i, shift_offset lane = i, clear m_l[i]. Lane with empty mask: column 8'h00, offset 3'd0. Outputs registered; weight_valid=1. zcip_done=1 iff all masks become empty after this beat. Beats per group = max over lanes of popcount(m_l); if every mask is zero at entry, exactly one beat of all-zero columns with zcip_done=1 (accumulator still receives a zero group).
- Latency: accept at edge t -> first beat valid after edge t+2 (t+1 registers masks, t+2 registers first beat).
- Back-pressure: a beat is consumed on an edge where weight_valid & out_ready. If weight_valid & !out_ready: go HOLD; all outputs held stable, masks not advanced. HOLD -> ISSUE (next beat computed) on out_ready. After final beat consumed: weight_valid=0, zcip_done=0, return IDLE.
- in_ready=0 in ISSUE/HOLD; in_valid ignored there (no new group overlaps).
- weight_sign_en constant for all beats of a group.
- Reset mid-group: group discarded, outputs zero next cycle, no zcip_done emitted.
- Output ordering per lane strictly ascending bit index.

Test Plan:
- Reset: assert rst 2 cycles mid-ISSUE -> next cycle weight_valid=0, zcip_done=0, in_ready=1 after release, state IDLE.
- Lane0 all weights 8'h01, other lanes 0, sign_mode=0, out_ready=1 -> single beat: column lane0=8'hFF, offsets all 0, zcip_done=1 on that beat; first valid 2 cycles after accept.
- Lane1 weight0=8'h85, sign_mode=1 -> beats: offset lane1 = 0 then 2 (bit 7 skipped), columns 8'h01,8'h01; zcip_done on 2nd beat; weight_sign_en=1 both beats. With sign_mode=0 -> 3 beats, offsets 0,2,7.
- Uneven lanes: lane0 mask 8'h0F, lane3 mask 8'h01 -> 4 beats; lane3 column 0 beat1, 8'h00/offset0 beats 2-4; zcip_done only on beat 4.
- All-zero group -> exactly one beat, weight_column=32'h0, zcip_done=1.
- Back-pressure: drop out_ready for 3 cycles on beat 2 of 4 -> outputs frozen, no beat lost or duplicated, total 4 consumed beats, zcip_done only on 4th.

Source files
------------

// File: rtl/zcip_weight_feeder.sv
// Zero-column-skipping weight feeder: transposes each lane's weights into
// bit-columns and issues only non-zero columns, lowest bit index first.
module zcip_weight_feeder #(
  parameter int LANES = 4,
  parameter int WBITS = 8,
  localparam int SW   = $clog2(WBITS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [LANES*WBITS*WBITS-1:0] weights_in,
  input  logic                         sign_mode,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         out_ready,
  output logic [LANES*WBITS-1:0]       weight_column,
  output logic [LANES*SW-1:0]          shift_offset,
  output logic                         weight_sign_en,
  output logic                         weight_valid,
  output logic                         zcip_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam int         LW      = WBITS * WBITS;

  logic [1:0]             state_q, state_d;
  logic                   load_q,  load_d;
  logic [LANES*LW-1:0]    wts_q,   wts_d;
  logic                   sign_q,  sign_d;
  logic [LANES*WBITS-1:0] mask_q,  mask_d;
  logic [LANES*WBITS-1:0] col_q,   col_d;
  logic [LANES*SW-1:0]    off_q,   off_d;
  logic                   valid_q, valid_d;
  logic                   done_q,  done_d;

  function automatic logic [WBITS-1:0] lane_mask(input logic [LW-1:0] w, input logic sgn);
    logic [WBITS-1:0] m;
    m = '0;
    for (int j = 0; j < WBITS; j++) m = m | w[j*WBITS +: WBITS];
    if (sgn) m[WBITS-1] = 1'b0;
    return m;
  endfunction

  function automatic logic [SW-1:0] lowest_bit(input logic [WBITS-1:0] m);
    logic [SW-1:0] idx;
    idx = '0;
    for (int i = WBITS-1; i >= 0; i--) begin
      if (m[i]) idx = SW'(i);
    end
    return idx;
  endfunction

  function automatic logic [WBITS-1:0] bit_column(input logic [LW-1:0] w, input logic [SW-1:0] idx);
    logic [WBITS-1:0] c;
    c = '0;
    for (int j = 0; j < WBITS; j++) c[j] = w[j*WBITS + int'(idx)];
    return c;
  endfunction

  assign in_ready       = (state_q == S_IDLE) && !rst;
  assign weight_column  = col_q;
  assign shift_offset   = off_q;
  assign weight_sign_en = sign_q;
  assign weight_valid   = valid_q;
  assign zcip_done      = done_q;

  // Next-state: load_q marks the mask-building cycle between accept and first beat.
  always_comb begin
    state_d = state_q;
    load_d  = load_q;
    wts_d   = wts_q;
    sign_d  = sign_q;
    mask_d  = mask_q;
    col_d   = col_q;
    off_d   = off_q;
    valid_d = valid_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          wts_d   = weights_in;
          sign_d  = sign_mode;
          load_d  = 1'b1;
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE, S_HOLD: begin
        if (load_q) begin
          for (int l = 0; l < LANES; l++)
            mask_d[l*WBITS +: WBITS] = lane_mask(wts_q[l*LW +: LW], sign_q);
          load_d = 1'b0;
        end else if (valid_q && !out_ready) begin
          state_d = S_HOLD;
        end else if (valid_q && done_q) begin
          col_d   = '0;
          off_d   = '0;
          valid_d = 1'b0;
          done_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          // Emit the lowest pending column per lane and retire that bit.
          for (int l = 0; l < LANES; l++) begin
            if (|mask_q[l*WBITS +: WBITS]) begin
              col_d[l*WBITS +: WBITS] = bit_column(wts_q[l*LW +: LW],
                                                   lowest_bit(mask_q[l*WBITS +: WBITS]));
              off_d[l*SW +: SW]       = lowest_bit(mask_q[l*WBITS +: WBITS]);
              mask_d[l*WBITS +: WBITS] = mask_q[l*WBITS +: WBITS] &
                                         (mask_q[l*WBITS +: WBITS] - WBITS'(1));
            end else begin
              col_d[l*WBITS +: WBITS] = '0;
              off_d[l*SW +: SW]       = '0;
            end
          end
          valid_d = 1'b1;
          done_d  = ~|mask_d;
          state_d = S_ISSUE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      load_q  <= 1'b0;
      wts_q   <= '0;
      sign_q  <= 1'b0;
      mask_q  <= '0;
      col_q   <= '0;
      off_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      wts_q   <= wts_d;
      sign_q  <= sign_d;
      mask_q  <= mask_d;
      col_q   <= col_d;
      off_q   <= off_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_zcip_weight_feeder.sv
// Directed self-checking bench for zcip_weight_feeder.
module tb_zcip_weight_feeder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] weights_in = '0;
  logic         sign_mode = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         out_ready = 1'b1;
  logic [31:0]  weight_column;
  logic [11:0]  shift_offset;
  logic         weight_sign_en;
  logic         weight_valid;
  logic         zcip_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] bcol[$];
  logic [11:0] boff[$];
  logic        bdone[$];
  logic        bsgn[$];

  always #5 clk = ~clk;

  zcip_weight_feeder dut (
    .clk(clk), .rst(rst), .weights_in(weights_in), .sign_mode(sign_mode),
    .in_valid(in_valid), .in_ready(in_ready), .out_ready(out_ready),
    .weight_column(weight_column), .shift_offset(shift_offset),
    .weight_sign_en(weight_sign_en), .weight_valid(weight_valid), .zcip_done(zcip_done)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic accept_group(input logic [255:0] w, input logic sm);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    weights_in = w;
    sign_mode  = sm;
    in_valid   = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check_eq("in_ready_wait", ok, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_group(input logic [255:0] w, input logic sm,
                           input int stall_beat, input int stall_len);
    int  bc, stall, first_cyc;
    bit  fin, fheld;
    logic [63:0] frozen;
    bcol.delete(); boff.delete(); bdone.delete(); bsgn.delete();
    bc = 0; stall = stall_len; first_cyc = -1; fin = 1'b0; fheld = 1'b0; frozen = '0;
    out_ready = 1'b1;
    accept_group(w, sm);
    for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
      @(negedge clk);
      if (fheld) check_eq("hold_frozen", {7'd0, zcip_done, weight_valid, shift_offset, weight_column}, frozen);
      if (weight_valid && first_cyc < 0) first_cyc = cyc;
      if (weight_valid) begin
        if (bc == stall_beat && stall > 0) begin
          out_ready = 1'b0;
          stall--;
          frozen = {7'd0, zcip_done, weight_valid, shift_offset, weight_column};
          fheld  = 1'b1;
        end else begin
          out_ready = 1'b1;
          fheld = 1'b0;
          bcol.push_back(weight_column);
          boff.push_back(shift_offset);
          bdone.push_back(zcip_done);
          bsgn.push_back(weight_sign_en);
          bc++;
          if (zcip_done) fin = 1'b1;
        end
      end else begin
        out_ready = 1'b1;
      end
    end
    check_eq("group_finished", fin, 1'b1);
    check_eq("first_beat_latency", first_cyc, 2);
    @(negedge clk);
    check_eq("post_valid", weight_valid, 1'b0);
    check_eq("post_done", zcip_done, 1'b0);
    check_eq("post_in_ready", in_ready, 1'b1);
  endtask

  task automatic expect_beat(input int k, input logic [31:0] col, input logic [11:0] off,
                             input logic done, input logic sgn);
    if (k < bcol.size()) begin
      check_eq("beat_col", bcol[k], col);
      check_eq("beat_off", boff[k], off);
      check_eq("beat_done", bdone[k], done);
      check_eq("beat_sign_en", bsgn[k], sgn);
    end else begin
      check_eq("beat_missing", bcol.size(), k + 1);
    end
  endtask

  initial begin
    logic [255:0] w;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_valid", weight_valid, 1'b0);
    check_eq("rst_done", zcip_done, 1'b0);
    check_eq("rst_col_off", {shift_offset, weight_column}, 44'd0);
    check_eq("rst_sign_en", weight_sign_en, 1'b0);
    check_eq("rst_in_ready", in_ready, 1'b0);
    rst = 1'b0;
    #1;
    check_eq("idle_in_ready", in_ready, 1'b1);

    // Lane0 all weights 1: one beat with full column at bit 0.
    w = '0;
    w[63:0] = 64'h0101_0101_0101_0101;
    run_group(w, 1'b0, -1, 0);
    check_eq("t1_nbeats", bcol.size(), 1);
    expect_beat(0, 32'h0000_00FF, 12'h000, 1'b1, 1'b0);

    // Lane1 weight0 = 0x85, sign-magnitude: bit 7 skipped.
    w = '0;
    w[64 +: 8] = 8'h85;
    run_group(w, 1'b1, -1, 0);
    check_eq("t2s_nbeats", bcol.size(), 2);
    expect_beat(0, 32'h0000_0100, 12'h000, 1'b0, 1'b1);
    expect_beat(1, 32'h0000_0100, 12'h010, 1'b1, 1'b1);

    // Same weights unsigned: offsets 0, 2, 7.
    run_group(w, 1'b0, -1, 0);
    check_eq("t2u_nbeats", bcol.size(), 3);
    expect_beat(0, 32'h0000_0100, 12'h000, 1'b0, 1'b0);
    expect_beat(1, 32'h0000_0100, 12'h010, 1'b0, 1'b0);
    expect_beat(2, 32'h0000_0100, 12'h038, 1'b1, 1'b0);

    // Uneven lanes: lane0 mask 0x0F, lane3 mask 0x01.
    w = '0;
    w[0 +: 8]   = 8'h03;
    w[8 +: 8]   = 8'h0C;
    w[208 +: 8] = 8'h01;
    run_group(w, 1'b0, -1, 0);
    check_eq("t4_nbeats", bcol.size(), 4);
    expect_beat(0, 32'h0400_0001, 12'h000, 1'b0, 1'b0);
    expect_beat(1, 32'h0000_0001, 12'h001, 1'b0, 1'b0);
    expect_beat(2, 32'h0000_0002, 12'h002, 1'b0, 1'b0);
    expect_beat(3, 32'h0000_0002, 12'h003, 1'b1, 1'b0);

    // Back-pressure: stall 3 cycles on beat 2 of the same group.
    run_group(w, 1'b0, 1, 3);
    check_eq("t6_nbeats", bcol.size(), 4);
    expect_beat(0, 32'h0400_0001, 12'h000, 1'b0, 1'b0);
    expect_beat(1, 32'h0000_0001, 12'h001, 1'b0, 1'b0);
    expect_beat(2, 32'h0000_0002, 12'h002, 1'b0, 1'b0);
    expect_beat(3, 32'h0000_0002, 12'h003, 1'b1, 1'b0);

    // All-zero group: exactly one zero beat.
    run_group('0, 1'b0, -1, 0);
    check_eq("t5_nbeats", bcol.size(), 1);
    expect_beat(0, 32'h0000_0000, 12'h000, 1'b1, 1'b0);

    // Only sign bits set in sign mode: masks empty, one zero beat.
    w = '0;
    w[128 +: 64] = 64'h8080_8080_8080_8080;
    run_group(w, 1'b1, -1, 0);
    check_eq("t7_nbeats", bcol.size(), 1);
    expect_beat(0, 32'h0000_0000, 12'h000, 1'b1, 1'b1);

    // Reset mid-group: start the uneven group, reset after first beat.
    w = '0;
    w[0 +: 8]   = 8'h03;
    w[8 +: 8]   = 8'h0C;
    w[208 +: 8] = 8'h01;
    out_ready = 1'b1;
    accept_group(w, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("mid_valid_before_rst", weight_valid, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_valid1", weight_valid, 1'b0);
    check_eq("mid_rst_done1", zcip_done, 1'b0);
    @(negedge clk);
    check_eq("mid_rst_valid2", weight_valid, 1'b0);
    check_eq("mid_rst_col", weight_column, 32'h0);
    check_eq("mid_rst_in_ready", in_ready, 1'b0);
    rst = 1'b0;
    #1;
    check_eq("mid_rel_in_ready", in_ready, 1'b1);
    repeat (3) @(negedge clk);
    check_eq("mid_idle_valid", weight_valid, 1'b0);

    // Fresh group after the reset behaves normally.
    w = '0;
    w[63:0] = 64'h0101_0101_0101_0101;
    run_group(w, 1'b0, -1, 0);
    check_eq("t8_nbeats", bcol.size(), 1);
    expect_beat(0, 32'h0000_00FF, 12'h000, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
